// File: rtl/oreg_snapshot_bank_if.sv
// ---------------------------------------------------------------------------
// oreg_snapshot_bank_if
// Bundles the sample input, control strobes and published snapshot of
// oreg_snapshot_bank.
//   data_i    : N_CH*WIDTH  coherent multi-channel sample, channel k at [k*WIDTH +: WIDTH]
//   valid_i   : 1           data_i holds a sample this cycle
//   clear_i   : 1           discard partial average and overrun count
//   ack_i     : 1           consumer has read oreg_o
//   oreg_o    : N_CH*WIDTH  published snapshot (same packing as data_i)
//   ready_o   : 1           unacknowledged snapshot present
//   seq_o     : 16          publish sequence number
//   overrun_o : 16          dropped snapshot count (saturating)
// master = producer/consumer side, slave = the snapshot bank.
// ---------------------------------------------------------------------------
interface oreg_snapshot_bank_if #(
  parameter int N_CH  = 3,
  parameter int WIDTH = 32
);
  logic [N_CH*WIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  clear_i;
  logic                  ack_i;
  logic [N_CH*WIDTH-1:0] oreg_o;
  logic                  ready_o;
  logic [15:0]           seq_o;
  logic [15:0]           overrun_o;

  modport master (
    output data_i, valid_i, clear_i, ack_i,
    input  oreg_o, ready_o, seq_o, overrun_o
  );

  modport slave (
    input  data_i, valid_i, clear_i, ack_i,
    output oreg_o, ready_o, seq_o, overrun_o
  );
endinterface

// File: rtl/oreg_snapshot_bank.sv
// ---------------------------------------------------------------------------
// oreg_snapshot_bank
// Averages blocks of 2^AVG_LOG2 coherent multi-channel samples and publishes
// each block result as a snapshot register with a ready/ack handshake.
// A completed block that arrives while an unacknowledged snapshot is held is
// dropped and counted in overrun_o.
// Ports:
//   clk    : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : oreg_snapshot_bank_if.slave (data_i/valid_i/clear_i/ack_i in,
//            oreg_o/ready_o/seq_o/overrun_o out)
// Parameters: N_CH channels, WIDTH bits each, AVG_LOG2 block size exponent,
//             SIGNED selects two's-complement (1) or unsigned (0) arithmetic.
// ---------------------------------------------------------------------------
module oreg_snapshot_bank #(
  parameter int N_CH     = 3,
  parameter int WIDTH    = 32,
  parameter int AVG_LOG2 = 0,
  parameter int SIGNED   = 1
) (
  input logic                 clk,
  input logic                 rst_ni,
  oreg_snapshot_bank_if.slave bus
);

  // Accumulator must hold 2^AVG_LOG2 samples without overflow.
  localparam int AW = WIDTH + AVG_LOG2;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic                  ready;
  logic                  accept;     // sample taken into the average
  logic                  block_end;  // current sample is the last of its block
  logic                  complete;
  logic                  publish;
  logic                  drop;
  logic [N_CH*WIDTH-1:0] result;
  logic [N_CH*WIDTH-1:0] oreg_reg;
  logic [15:0]           seq_reg;
  logic [15:0]           overrun_reg;

  // clear_i wins over a coincident valid_i: that sample is discarded.
  assign accept   = bus.valid_i && !bus.clear_i;
  assign complete = accept && block_end;
  assign publish  = complete && ((state_reg == EMPTY) || bus.ack_i);
  assign drop     = complete && (state_reg == HELD) && !bus.ack_i;

  // -------------------------------------------------------------------------
  // Sample counter: only exists when blocks are longer than one sample.
  // It wraps naturally from all-ones to zero on the closing sample.
  // -------------------------------------------------------------------------
  generate
    if (AVG_LOG2 == 0) begin : g_nocnt
      assign block_end = 1'b1;
    end else begin : g_cnt
      logic [AVG_LOG2-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_reg <= '0;
        end else if (bus.clear_i) begin
          cnt_reg <= '0;
        end else if (bus.valid_i) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign block_end = (cnt_reg == {AVG_LOG2{1'b1}});
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Per-channel accumulate and block result.
  // The result is formed from acc + current sample so the closing sample is
  // included without an extra cycle; the accumulator then restarts at 0.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] sample;
      logic [AW-1:0]    ext;
      logic [AW-1:0]    sum;
      logic [AW-1:0]    acc_reg;

      assign sample = bus.data_i[gi*WIDTH +: WIDTH];

      if (SIGNED != 0) begin : g_signed
        assign ext = AW'($signed(sample));
        assign result[gi*WIDTH +: WIDTH] = WIDTH'($signed(sum) >>> AVG_LOG2);
      end else begin : g_unsigned
        assign ext = AW'(sample);
        assign result[gi*WIDTH +: WIDTH] = WIDTH'(sum >> AVG_LOG2);
      end

      assign sum = acc_reg + ext;

      always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
          acc_reg <= '0;
        end else if (bus.clear_i) begin
          acc_reg <= '0;
        end else if (bus.valid_i) begin
          acc_reg <= complete ? '0 : sum;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Snapshot register, sequence number and overrun counter.
  // clear_i touches only the overrun counter here; the held snapshot stays.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      oreg_reg <= '0;
      seq_reg  <= '0;
    end else if (publish) begin
      oreg_reg <= result;
      seq_reg  <= seq_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun_reg <= '0;
    end else if (bus.clear_i) begin
      overrun_reg <= '0;
    end else if (drop && (overrun_reg != 16'hFFFF)) begin
      overrun_reg <= overrun_reg + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Handshake FSM: EMPTY (nothing to read) / HELD (snapshot awaiting ack).
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: begin
        if (publish) state_next = HELD;
      end
      HELD: begin
        // publish with ack keeps HELD; ack alone releases the snapshot
        if (!publish && bus.ack_i) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    ready = (state_reg == HELD);
  end

  assign bus.oreg_o    = oreg_reg;
  assign bus.ready_o   = ready;
  assign bus.seq_o     = seq_reg;
  assign bus.overrun_o = overrun_reg;

endmodule
